sram_read_prefetch: RTL and testbench

SRAM_READ_PREFETCH -- requirements
Module: sram_read_prefetch

---
 rtl/sram_prefetch_pkg.sv | 32 +++
 rtl/prefetch_fifo.sv | 96 +++++++++
 rtl/sram_read_prefetch.sv | 145 ++++++++++++++
 tb/tb_sram_read_prefetch.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_prefetch_pkg.sv
// sram_prefetch_pkg
//
// Shared definitions for the SRAM read prefetcher:
//   - state_t             : fetch FSM states
//   - ADDR_W / DATA_W     : SRAM word address and data widths
//   - DEFAULT_BASE_ADDR   : default first word address of a frame
//   - DEFAULT_FRAME_WORDS : default 16-bit words per frame (640x480)
//   - DEFAULT_FIFO_DEPTH  : default prefetch FIFO entries
//   - cnt_width()         : word counter width for a given frame size

package sram_prefetch_pkg;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 16;

    localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR   = 20'h00000;
    localparam int unsigned       DEFAULT_FRAME_WORDS = 307200;
    localparam int unsigned       DEFAULT_FIFO_DEPTH  = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StFull  = 2'd2,
        StDone  = 2'd3
    } state_t;

    // Guards against a zero-width counter for degenerate one-word frames.
    function automatic int unsigned cnt_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo
//
// Synchronous FIFO with a registered head word.
//   clk    : clock, all state on posedge
//   rst_n  : asynchronous active-low reset (FIFO empty, head = 0)
//   flush  : synchronous clear; wins over a same-cycle push or pop
//   push   : write din (accepted when not full, or when full with a pop)
//   din    : write data
//   pop    : remove head word (ignored when empty)
//   head   : registered head word, meaningful while empty = 0
//   full   : DEPTH entries stored
//   empty  : no entries stored
//
// DEPTH must be a power of two so the pointers wrap naturally.

module prefetch_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q, rd_next;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign head  = head_q;

    always_comb begin
        do_pop  = pop && !empty;
        // A full FIFO can still take a word when the head leaves this cycle.
        do_push = push && (!full || do_pop);
        rd_next = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Head tracks the slot rd_next will point at; bypass the incoming
        // word when it lands in that slot this cycle.
        head_d = head_q;
        if (count_d != '0) begin
            if (do_push && (wr_ptr_q == rd_next)) begin
                head_d = din;
            end else begin
                head_d = mem[rd_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_next;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

endmodule

// File: rtl/sram_read_prefetch.sv
// sram_read_prefetch
//
// Walks a frame of SRAM words starting at BASE_ADDR and buffers them in a
// small FIFO ahead of a pixel consumer.
//   Clk          : single clock, all logic on posedge
//   Reset_n      : asynchronous active-low reset
//   Frame_start  : one-cycle pulse; flushes the FIFO and restarts at BASE_ADDR
//   Read_ready   : Data_read holds the word for the current Read_ADDR
//   Data_read    : SRAM read word
//   Read_ADDR    : word address presented to the SRAM interface
//   Pixel_pop    : consumer takes the head word this cycle
//   Pixel_data   : registered FIFO head word
//   Pixel_valid  : FIFO not empty
//   Frame_done   : every word of the current frame has been captured
//   Underrun_cnt : (PREFETCH_UNDERRUN_CNT_EN only) saturating count of pops
//                  seen while the FIFO was empty
//
// Optional feature macro: PREFETCH_UNDERRUN_CNT_EN.

module sram_read_prefetch
    import sram_prefetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned       FRAME_WORDS = DEFAULT_FRAME_WORDS,
    parameter int unsigned       FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Frame_start,
    input  logic              Read_ready,
    input  logic [DATA_W-1:0] Data_read,
    output logic [ADDR_W-1:0] Read_ADDR,
    input  logic              Pixel_pop,
    output logic [DATA_W-1:0] Pixel_data,
    output logic              Pixel_valid,
    output logic              Frame_done
`ifdef PREFETCH_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       Underrun_cnt
`endif
);

    localparam int unsigned       CNT_W    = cnt_width(FRAME_WORDS);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(FRAME_WORDS - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  word_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              done_q;

    logic fifo_full, fifo_empty;
    logic capture_ok, fifo_push, fifo_pop;

    always_comb begin
        capture_ok = Read_ready && (!fifo_full || Pixel_pop);
        // Frame_start outranks any capture or pop in the same cycle.
        fifo_push  = (state_q == StFetch) && capture_ok && !Frame_start;
        fifo_pop   = Pixel_pop && !Frame_start;
    end

    prefetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (Clk),
        .rst_n (Reset_n),
        .flush (Frame_start),
        .push  (fifo_push),
        .din   (Data_read),
        .pop   (fifo_pop),
        .head  (Pixel_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Read_ADDR is kept equal to BASE_ADDR + word counter as a register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= StIdle;
            word_cnt_q <= '0;
            addr_q     <= BASE_ADDR;
            done_q     <= 1'b0;
        end else if (Frame_start) begin
            state_q    <= StFetch;
            word_cnt_q <= '0;
            addr_q     <= BASE_ADDR;
            done_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    addr_q <= BASE_ADDR;
                end
                StFetch: begin
                    if (Read_ready) begin
                        if (capture_ok) begin
                            if (word_cnt_q == LAST_IDX) begin
                                word_cnt_q <= '0;
                                addr_q     <= BASE_ADDR;
                                done_q     <= 1'b1;
                                state_q    <= StDone;
                            end else begin
                                word_cnt_q <= word_cnt_q + 1'b1;
                                addr_q     <= addr_q + 20'd1;
                            end
                        end else begin
                            state_q <= StFull;
                        end
                    end
                end
                StFull: begin
                    if (Pixel_pop) begin
                        state_q <= StFetch;
                    end
                end
                StDone: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign Read_ADDR   = addr_q;
    assign Pixel_valid = !fifo_empty;
    assign Frame_done  = done_q;

`ifdef PREFETCH_UNDERRUN_CNT_EN
    logic [15:0] underrun_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            underrun_q <= '0;
        end else if (Frame_start) begin
            underrun_q <= '0;
        end else if (Pixel_pop && fifo_empty && (underrun_q != 16'hFFFF)) begin
            underrun_q <= underrun_q + 16'd1;
        end
    end

    assign Underrun_cnt = underrun_q;
`endif

endmodule

// File: tb/tb_sram_read_prefetch.sv
// tb_sram_read_prefetch
//
// Instance A: default frame size, 16-entry FIFO, driven from a vector table.
// Instance B: 8-word frame, checked through a scoreboard queue of expected
// pixel words. Data_read always mirrors the low 16 bits of Read_ADDR.

module tb_sram_read_prefetch;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // Instance A signals
    logic        a_start = 1'b0, a_rdy = 1'b0, a_pop = 1'b0;
    logic [15:0] a_data, a_pdata;
    logic [19:0] a_addr;
    logic        a_pvalid, a_done;
    // Instance B signals
    logic        b_start = 1'b0, b_rdy = 1'b0, b_pop = 1'b0;
    logic [15:0] b_data, b_pdata;
    logic [19:0] b_addr;
    logic        b_pvalid, b_done;
`ifdef PREFETCH_UNDERRUN_CNT_EN
    logic [15:0] a_under, b_under;
`endif

    assign a_data = a_addr[15:0];
    assign b_data = b_addr[15:0];

    sram_read_prefetch dut_a (
        .Clk          (clk),
        .Reset_n      (rst_n),
        .Frame_start  (a_start),
        .Read_ready   (a_rdy),
        .Data_read    (a_data),
        .Read_ADDR    (a_addr),
        .Pixel_pop    (a_pop),
        .Pixel_data   (a_pdata),
        .Pixel_valid  (a_pvalid),
        .Frame_done   (a_done)
`ifdef PREFETCH_UNDERRUN_CNT_EN
        ,
        .Underrun_cnt (a_under)
`endif
    );

    sram_read_prefetch #(
        .BASE_ADDR   (20'h00000),
        .FRAME_WORDS (8),
        .FIFO_DEPTH  (16)
    ) dut_b (
        .Clk          (clk),
        .Reset_n      (rst_n),
        .Frame_start  (b_start),
        .Read_ready   (b_rdy),
        .Data_read    (b_data),
        .Read_ADDR    (b_addr),
        .Pixel_pop    (b_pop),
        .Pixel_data   (b_pdata),
        .Pixel_valid  (b_pvalid),
        .Frame_done   (b_done)
`ifdef PREFETCH_UNDERRUN_CNT_EN
        ,
        .Underrun_cnt (b_under)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        start;
        logic        rdy;
        logic        pop;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic [19:0] exp_addr;
        logic        exp_done;
        logic        chk_data;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] sb[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic r, input logic p, input logic v,
                       input logic [15:0] d, input logic [19:0] a, input logic dn,
                       input logic cd);
        vec_t t;
        t.start = s; t.rdy = r; t.pop = p; t.exp_valid = v;
        t.exp_data = d; t.exp_addr = a; t.exp_done = dn; t.chk_data = cd;
        vecs.push_back(t);
    endtask

    task automatic step_a(input logic s, input logic r, input logic p);
        @(negedge clk);
        a_start = s; a_rdy = r; a_pop = p;
        @(posedge clk);
        #1;
        a_start = 1'b0; a_rdy = 1'b0; a_pop = 1'b0;
    endtask

    initial begin
        int          cap;
        int          got;
        logic [19:0] exp_b_addr;

        // Table for instance A: fill, FULL hold, pop, push+pop on full, flush.
        add(1, 0, 0, 0, 16'h0, 20'h0, 0, 0);
        for (int k = 1; k <= 16; k++) add(0, 1, 0, 1, 16'h0, 20'(k), 0, 1);
        add(0, 1, 0, 1, 16'h0, 20'h10, 0, 1);
        add(0, 1, 0, 1, 16'h0, 20'h10, 0, 1);
        add(0, 1, 1, 1, 16'h1, 20'h10, 0, 1);
        add(0, 1, 0, 1, 16'h1, 20'h11, 0, 1);
        add(0, 1, 1, 1, 16'h2, 20'h12, 0, 1);
        add(0, 0, 1, 1, 16'h3, 20'h12, 0, 1);
        add(1, 1, 1, 0, 16'h0, 20'h0, 0, 0);
        add(0, 0, 0, 0, 16'h0, 20'h0, 0, 0);
        add(0, 1, 0, 1, 16'h0, 20'h1, 0, 1);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset addr", 32'(a_addr), 32'h0);
        check("reset valid", 32'(a_pvalid), 32'h0);
        check("reset data", 32'(a_pdata), 32'h0);
        check("reset done", 32'(a_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE ignores Read_ready before any Frame_start
        step_a(0, 1, 0);
        check("idle addr", 32'(a_addr), 32'h0);
        check("idle valid", 32'(a_pvalid), 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            step_a(vecs[i].start, vecs[i].rdy, vecs[i].pop);
            check($sformatf("vec%0d valid", i), 32'(a_pvalid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d addr", i), 32'(a_addr), 32'(vecs[i].exp_addr));
            check($sformatf("vec%0d done", i), 32'(a_done), 32'(vecs[i].exp_done));
            if (vecs[i].chk_data) begin
                check($sformatf("vec%0d data", i), 32'(a_pdata), 32'(vecs[i].exp_data));
            end
        end

        // Instance B: 8-word frame with continuous pop, scoreboard on words.
        @(negedge clk);
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        cap = 0;
        got = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (b_pvalid) begin
                if (sb.size() == 0) begin
                    check("b extra word", 32'(b_pdata), 32'hFFFF_FFFF);
                end else begin
                    check($sformatf("b word%0d", got), 32'(b_pdata), 32'(sb.pop_front()));
                    got++;
                end
            end
            b_rdy = 1'b1;
            b_pop = 1'b1;
            if (cap < 8) begin
                sb.push_back(16'(cap));
                cap++;
            end
            @(posedge clk);
            #1;
            exp_b_addr = (cap < 8) ? 20'(cap) : 20'h0;
            check($sformatf("b step%0d addr", i), 32'(b_addr), 32'(exp_b_addr));
            check($sformatf("b step%0d done", i), 32'(b_done), 32'(cap == 8));
        end
        @(negedge clk);
        b_rdy = 1'b0;
        b_pop = 1'b0;
        check("b words out", 32'(got), 32'd8);
        check("b sb empty", 32'(sb.size()), 32'd0);
        check("b drained", 32'(b_pvalid), 32'h0);
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        check("b restart done", 32'(b_done), 32'h0);
        check("b restart addr", 32'(b_addr), 32'h0);

        // Asynchronous reset mid-frame on A (holds one word, addr 1).
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async addr", 32'(a_addr), 32'h0);
        check("async valid", 32'(a_pvalid), 32'h0);
        check("async data", 32'(a_pdata), 32'h0);
        check("async done", 32'(a_done), 32'h0);
        #1;
        rst_n = 1'b1;
        step_a(0, 1, 0);
        check("post-reset idle addr", 32'(a_addr), 32'h0);
        check("post-reset idle valid", 32'(a_pvalid), 32'h0);

`ifdef PREFETCH_UNDERRUN_CNT_EN
        check("underrun reset", 32'(a_under), 32'h0);
        repeat (3) step_a(0, 0, 1);
        check("underrun three", 32'(a_under), 32'd3);
        step_a(1, 0, 0);
        check("underrun cleared", 32'(a_under), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
